uart_tx_block: RTL



---
 rtl/uart_tx_block.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_block.sv
// UART transmitter: one-entry holding buffer feeding an 8N1 serializer.
// Each serial bit lasts BIT_PERIOD clocks; serial_out idles high.
module uart_tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       data_write,
  output logic       buffer_ready,
  output logic       tx_active,
  output logic       write_error,
  output logic       serial_out
);

  localparam int TW = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_reg;
  logic [7:0]      holding_reg;
  logic [7:0]      shift_reg;
  logic [TW-1:0]   timer_reg;
  logic [2:0]      bit_cnt_reg;
  logic            buffer_ready_reg;
  logic            tx_active_reg;
  logic            write_error_reg;
  logic            serial_out_reg;
  logic            bit_done;

  assign bit_done     = (timer_reg == BIT_LAST);
  assign buffer_ready = buffer_ready_reg;
  assign tx_active    = tx_active_reg;
  assign write_error  = write_error_reg;
  assign serial_out   = serial_out_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg        <= IDLE;
      holding_reg      <= 8'h00;
      shift_reg        <= 8'h00;
      timer_reg        <= '0;
      bit_cnt_reg      <= 3'd0;
      buffer_ready_reg <= 1'b1;
      tx_active_reg    <= 1'b0;
      write_error_reg  <= 1'b0;
      serial_out_reg   <= 1'b1;
    end else begin
      // A write is taken only while the buffer is empty; otherwise it is dropped and flagged.
      write_error_reg <= data_write && !buffer_ready_reg;
      if (data_write && buffer_ready_reg) begin
        holding_reg      <= tx_data;
        buffer_ready_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          serial_out_reg <= 1'b1;
          if (!buffer_ready_reg) begin
            state_reg     <= LOAD;
            tx_active_reg <= 1'b1;
          end
        end

        // The buffer can never accept a write in this cycle, so clearing it here is safe.
        LOAD: begin
          shift_reg        <= holding_reg;
          holding_reg      <= 8'h00;
          buffer_ready_reg <= 1'b1;
          serial_out_reg   <= 1'b0;
          timer_reg        <= '0;
          state_reg        <= START;
        end

        START: begin
          if (bit_done) begin
            timer_reg      <= '0;
            bit_cnt_reg    <= 3'd0;
            serial_out_reg <= shift_reg[0];
            state_reg      <= DATA;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            timer_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              serial_out_reg <= 1'b1;
              state_reg      <= STOP;
            end else begin
              bit_cnt_reg    <= bit_cnt_reg + 3'd1;
              shift_reg      <= {1'b0, shift_reg[7:1]};
              serial_out_reg <= shift_reg[1];
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            timer_reg <= '0;
            if (!buffer_ready_reg) begin
              state_reg <= LOAD;
            end else begin
              state_reg     <= IDLE;
              tx_active_reg <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        default: begin
          state_reg      <= IDLE;
          tx_active_reg  <= 1'b0;
          serial_out_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule
